// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared constants and helpers for the byte FIFO read side
package fifo_pkg;

    localparam int FIFO_DATA_WIDTH = 8;

    // Flush FSM: FILL accumulates normally, DRAIN holds pops until the partial word leaves
    localparam logic [0:0] ST_FILL  = 1'b0;
    localparam logic [0:0] ST_DRAIN = 1'b1;

    // Low 'count' bits set; count of 8 yields all ones
    function automatic logic [7:0] keep_from_count(input logic [3:0] count);
        logic [8:0] ones;
        ones = (9'd1 << count) - 9'd1;
        return ones[7:0];
    endfunction

endpackage

// File: rtl/word_out_reg.sv
// rtl/word_out_reg.sv - output holding register with valid/ready handshake
module word_out_reg #(
    parameter int WIDTH      = 32,
    parameter int KEEP_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_data,
    input  logic [KEEP_WIDTH-1:0] load_keep,
    input  logic                  ready,
    output logic                  valid,
    output logic [WIDTH-1:0]      data,
    output logic [KEEP_WIDTH-1:0] keep,
    output logic                  free
);

    // Register can take a new word when empty or when its current word leaves this cycle
    assign free = !valid || ready;

    // Hold the word until accepted; a load in the acceptance cycle replaces it directly
    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            data  <= '0;
            keep  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
            keep  <= load_keep;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fifo_byte_packer.sv
// rtl/fifo_byte_packer.sv - pops bytes from the BRAM FIFO and packs them into keep-masked words
module fifo_byte_packer
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH     = FIFO_DATA_WIDTH,
    parameter int BYTES_PER_WORD = 4
) (
    input  logic                                 Clk,
    input  logic                                 Reset,
    input  logic                                 FIFO_Empty,
    output logic                                 FIFO_Read,
    input  logic [DATA_WIDTH-1:0]                FIFO_Read_data,
    input  logic                                 Flush,
    output logic                                 Word_valid,
    input  logic                                 Word_ready,
    output logic [DATA_WIDTH*BYTES_PER_WORD-1:0] Word_data,
    output logic [BYTES_PER_WORD-1:0]            Word_keep,
    output logic                                 Idle
);

    localparam int WW = DATA_WIDTH * BYTES_PER_WORD;
    localparam int CW = $clog2(BYTES_PER_WORD + 1);
    localparam int IW = $clog2(BYTES_PER_WORD);
    localparam logic [CW-1:0] FULL = CW'(BYTES_PER_WORD);

    logic [BYTES_PER_WORD-1:0][DATA_WIDTH-1:0] acc;
    logic [CW-1:0]             count;
    logic [CW-1:0]             count_next;
    logic                      inflight;
    logic [0:0]                state;
    logic [0:0]                state_next;
    logic                      flush_pending;
    logic [CW:0]               occupancy;
    logic                      out_free;
    logic                      full_xfer;
    logic                      part_xfer;
    logic                      empty_clear;
    logic                      load;
    logic                      valid_next;
    logic [7:0]                keep_wide;
    logic [BYTES_PER_WORD-1:0] load_keep;
    logic [WW-1:0]             load_data;

    assign flush_pending = (state == ST_DRAIN);
    assign occupancy     = {1'b0, count} + {{CW{1'b0}}, inflight};

    // Reset also gates the pop: the FIFO is being cleared alongside, so nothing may be taken from it
    assign FIFO_Read = !Reset && !FIFO_Empty && !flush_pending && (occupancy < {1'b0, FULL});

    assign full_xfer   = out_free && (count == FULL);
    assign part_xfer   = out_free && flush_pending && !inflight && (count != '0);
    assign empty_clear = flush_pending && !inflight && (count == '0);
    assign load        = full_xfer || part_xfer;
    assign valid_next  = load || (Word_valid && !Word_ready);

    assign keep_wide = keep_from_count(4'(count));
    assign load_keep = keep_wide[BYTES_PER_WORD-1:0];

    // Build the outgoing word, zeroing lanes beyond the accumulated count
    always_comb begin
        load_data = '0;
        for (int i = 0; i < BYTES_PER_WORD; i++) begin
            if (load_keep[i]) begin
                load_data[i*DATA_WIDTH +: DATA_WIDTH] = acc[i];
            end
        end
    end

    // Next count and flush FSM state
    always_comb begin
        count_next = count;
        if (load) begin
            count_next = '0;
        end else if (inflight) begin
            count_next = count + CW'(1);
        end
        state_next = state;
        if (state == ST_FILL) begin
            if (Flush) begin
                state_next = ST_DRAIN;
            end
        end else if (part_xfer || empty_clear) begin
            state_next = ST_FILL;
        end
    end

    // Accumulator control state and the registered Idle flag
    always_ff @(posedge Clk) begin
        if (Reset) begin
            count    <= '0;
            inflight <= 1'b0;
            state    <= ST_FILL;
            Idle     <= 1'b1;
        end else begin
            count    <= count_next;
            inflight <= FIFO_Read;
            state    <= state_next;
            Idle     <= (count_next == '0) && !FIFO_Read && (state_next == ST_FILL) && !valid_next;
        end
    end

    // Byte lanes; stale lanes are masked on transfer so they need no reset
    always_ff @(posedge Clk) begin
        if (inflight) begin
            acc[count[IW-1:0]] <= FIFO_Read_data;
        end
    end

    word_out_reg #(
        .WIDTH      (WW),
        .KEEP_WIDTH (BYTES_PER_WORD)
    ) u_word_out_reg (
        .clk       (Clk),
        .reset     (Reset),
        .load      (load),
        .load_data (load_data),
        .load_keep (load_keep),
        .ready     (Word_ready),
        .valid     (Word_valid),
        .data      (Word_data),
        .keep      (Word_keep),
        .free      (out_free)
    );

endmodule

// File: tb/tb_fifo_byte_packer.sv
// tb/tb_fifo_byte_packer.sv - randomized self-checking bench for fifo_byte_packer
module tb_fifo_byte_packer;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        FIFO_Empty;
    logic        FIFO_Read;
    logic [7:0]  FIFO_Read_data = 8'h00;
    logic        Flush = 1'b0;
    logic        Word_valid;
    logic        Word_ready = 1'b0;
    logic [31:0] Word_data;
    logic [3:0]  Word_keep;
    logic        Idle;

    int passed = 0;
    int total  = 0;

    logic [7:0]  mem [0:1023];
    logic [9:0]  wr_ptr = 10'd0;
    logic [9:0]  rd_ptr = 10'd0;
    logic        hold_empty = 1'b0;

    logic [35:0] obs_q [$];
    logic [35:0] exp_q [$];
    int          valid_cycles = 0;
    int          stab_err = 0;
    logic        prev_stall = 1'b0;
    logic [35:0] prev_word = 36'd0;

    fifo_byte_packer #(.DATA_WIDTH(8), .BYTES_PER_WORD(4)) dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .FIFO_Empty     (FIFO_Empty),
        .FIFO_Read      (FIFO_Read),
        .FIFO_Read_data (FIFO_Read_data),
        .Flush          (Flush),
        .Word_valid     (Word_valid),
        .Word_ready     (Word_ready),
        .Word_data      (Word_data),
        .Word_keep      (Word_keep),
        .Idle           (Idle)
    );

    always #5 Clk = ~Clk;

    // FIFO model: read data appears in the cycle after the pop
    assign FIFO_Empty = hold_empty || (rd_ptr == wr_ptr);
    always @(posedge Clk) begin
        if (FIFO_Read) begin
            FIFO_Read_data <= mem[rd_ptr];
            rd_ptr <= rd_ptr + 10'd1;
        end
    end

    // Stream monitor: accepted words and hold-stability under backpressure
    always @(negedge Clk) begin
        if (Word_valid) valid_cycles++;
        if (prev_stall && !Reset && (!Word_valid || {Word_keep, Word_data} !== prev_word)) stab_err++;
        prev_stall = Word_valid && !Word_ready && !Reset;
        prev_word  = {Word_keep, Word_data};
        if (Word_valid && Word_ready) obs_q.push_back({Word_keep, Word_data});
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr_ptr] = b;
        wr_ptr = wr_ptr + 10'd1;
    endtask

    // Reference: little-endian groups of four, plus a keep-masked remainder when flushed
    function automatic void model_pack(input logic [7:0] b[$], input bit flush);
        int i;
        logic [31:0] d;
        logic [3:0]  k;
        exp_q.delete();
        i = 0;
        while (b.size() - i >= 4) begin
            exp_q.push_back({4'hF, b[i+3], b[i+2], b[i+1], b[i]});
            i += 4;
        end
        if (flush && i < b.size()) begin
            d = 32'd0;
            k = 4'd0;
            for (int j = 0; j < b.size() - i; j++) begin
                d[8*j +: 8] = b[i+j];
                k[j] = 1'b1;
            end
            exp_q.push_back({k, d});
        end
    endfunction

    task automatic test_reset();
        push(8'hAA);
        push(8'hBB);
        for (int i = 0; i < 2; i++) begin
            tick();
            #3;
            total++; if (FIFO_Read !== 1'b0) $display("FAIL reset_read got %b want 0", FIFO_Read); else passed++;
            total++; if (Word_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", Word_valid); else passed++;
            total++; if (Word_data !== 32'd0) $display("FAIL reset_data got %h want 0", Word_data); else passed++;
            total++; if (Idle !== 1'b1) $display("FAIL reset_idle got %b want 1", Idle); else passed++;
        end
        tick();
        Reset = 1'b0;
        wr_ptr = rd_ptr;
        for (int i = 0; i < 2; i++) begin
            #3;
            total++; if (FIFO_Read !== 1'b0) $display("FAIL post_reset_read got %b want 0", FIFO_Read); else passed++;
            total++; if (Word_valid !== 1'b0) $display("FAIL post_reset_valid got %b want 0", Word_valid); else passed++;
            total++; if (Word_keep !== 4'd0) $display("FAIL post_reset_keep got %h want 0", Word_keep); else passed++;
            total++; if (Idle !== 1'b1) $display("FAIL post_reset_idle got %b want 1", Idle); else passed++;
            tick();
        end
    endtask

    task automatic test_stream();
        logic [7:0] b[$];
        int base, rd_at, wv_at;
        base = obs_q.size();
        rd_at = -1;
        wv_at = -1;
        for (int i = 1; i <= 8; i++) b.push_back(8'(i));
        model_pack(b, 1'b0);
        Word_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (k == 0) foreach (b[i]) push(b[i]);
            #3;
            if (FIFO_Read && rd_at < 0) rd_at = k;
            if (Word_valid && wv_at < 0) wv_at = k;
        end
        total++; if (wv_at - rd_at !== 6) $display("FAIL stream_latency got %0d want 6", wv_at - rd_at); else passed++;
        total++; if (obs_q.size() - base !== exp_q.size()) $display("FAIL stream_count got %0d want %0d", obs_q.size() - base, exp_q.size()); else passed++;
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (base + i >= obs_q.size() || obs_q[base+i] !== exp_q[i]) $display("FAIL stream_word%0d got %h want %h", i, (base + i < obs_q.size()) ? obs_q[base+i] : 36'd0, exp_q[i]);
            else passed++;
        end
        total++; if (Idle !== 1'b1) $display("FAIL stream_idle got %b want 1", Idle); else passed++;
    endtask

    task automatic test_backpressure();
        logic [7:0] b[$];
        int base, rds, unstable;
        logic [35:0] held;
        logic got;
        base = obs_q.size();
        rds = 0;
        unstable = 0;
        got = 1'b0;
        held = 36'd0;
        for (int i = 1; i <= 12; i++) b.push_back(8'(i));
        model_pack(b, 1'b0);
        Word_ready = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (k == 0) foreach (b[i]) push(b[i]);
            #3;
            if (FIFO_Read) rds++;
            if (Word_valid && !got) begin
                got = 1'b1;
                held = {Word_keep, Word_data};
            end else if (got && {Word_keep, Word_data, Word_valid} !== {held, 1'b1}) begin
                unstable++;
            end
        end
        total++; if (rds !== 8) $display("FAIL bp_pops got %0d want 8", rds); else passed++;
        total++; if (held !== exp_q[0]) $display("FAIL bp_held got %h want %h", held, exp_q[0]); else passed++;
        total++; if (unstable !== 0) $display("FAIL bp_stable got %0d want 0", unstable); else passed++;
        total++; if (FIFO_Read !== 1'b0) $display("FAIL bp_read_stopped got %b want 0", FIFO_Read); else passed++;
        tick();
        Word_ready = 1'b1;
        for (int k = 0; k < 40; k++) tick();
        total++; if (obs_q.size() - base !== exp_q.size()) $display("FAIL bp_count got %0d want %0d", obs_q.size() - base, exp_q.size()); else passed++;
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (base + i >= obs_q.size() || obs_q[base+i] !== exp_q[i]) $display("FAIL bp_word%0d got %h want %h", i, (base + i < obs_q.size()) ? obs_q[base+i] : 36'd0, exp_q[i]);
            else passed++;
        end
        #3;
        total++; if (Idle !== 1'b1) $display("FAIL bp_idle got %b want 1", Idle); else passed++;
    endtask

    task automatic test_flush_partial();
        logic [7:0] b[$];
        int base;
        base = obs_q.size();
        b = '{8'h0A, 8'h0B, 8'h0C};
        model_pack(b, 1'b1);
        Word_ready = 1'b1;
        tick();
        foreach (b[i]) push(b[i]);
        for (int k = 0; k < 10; k++) tick();
        #3;
        total++; if (Word_valid !== 1'b0) $display("FAIL flush_no_early_word got %b want 0", Word_valid); else passed++;
        tick();
        Flush = 1'b1;
        tick();
        Flush = 1'b0;
        tick();
        #3;
        total++; if (Word_valid !== 1'b1) $display("FAIL flush_latency got %b want 1", Word_valid); else passed++;
        for (int k = 0; k < 5; k++) tick();
        total++; if (obs_q.size() - base !== exp_q.size()) $display("FAIL flush_count got %0d want %0d", obs_q.size() - base, exp_q.size()); else passed++;
        total++;
        if (obs_q.size() <= base || obs_q[base] !== exp_q[0]) $display("FAIL flush_word got %h want %h", (base < obs_q.size()) ? obs_q[base] : 36'd0, exp_q[0]);
        else passed++;
        #3;
        total++; if (Idle !== 1'b1) $display("FAIL flush_idle got %b want 1", Idle); else passed++;
    endtask

    task automatic test_empty_flush();
        int vbase;
        vbase = valid_cycles;
        tick();
        Flush = 1'b1;
        tick();
        Flush = 1'b0;
        #3;
        total++; if (Idle !== 1'b0) $display("FAIL eflush_pending_idle got %b want 0", Idle); else passed++;
        tick();
        #3;
        total++; if (Idle !== 1'b1) $display("FAIL eflush_cleared_idle got %b want 1", Idle); else passed++;
        for (int k = 0; k < 5; k++) tick();
        total++; if (valid_cycles !== vbase) $display("FAIL eflush_no_word got %0d want %0d", valid_cycles, vbase); else passed++;
    endtask

    task automatic test_empty_gating();
        logic [7:0] b[$];
        int base, rds;
        base = obs_q.size();
        rds = 0;
        b = '{8'h21, 8'h22, 8'h23, 8'h24};
        model_pack(b, 1'b0);
        Word_ready = 1'b1;
        tick();
        push(b[0]);
        push(b[1]);
        for (int k = 0; k < 6; k++) tick();
        hold_empty = 1'b1;
        push(b[2]);
        push(b[3]);
        for (int k = 0; k < 5; k++) begin
            #3;
            if (FIFO_Read) rds++;
            tick();
        end
        total++; if (rds !== 0) $display("FAIL gate_reads got %0d want 0", rds); else passed++;
        total++; if (obs_q.size() !== base) $display("FAIL gate_no_word got %0d want %0d", obs_q.size(), base); else passed++;
        hold_empty = 1'b0;
        for (int k = 0; k < 20; k++) tick();
        total++;
        if (obs_q.size() - base !== 1 || obs_q[base] !== exp_q[0]) $display("FAIL gate_word got %h want %h", (base < obs_q.size()) ? obs_q[base] : 36'd0, exp_q[0]);
        else passed++;
    endtask

    task automatic test_reset_midword();
        logic [7:0] b[$];
        int base;
        Word_ready = 1'b1;
        tick();
        push(8'h31);
        push(8'h32);
        tick();
        tick();
        Reset = 1'b1;
        wr_ptr = rd_ptr;
        tick();
        tick();
        Reset = 1'b0;
        base = obs_q.size();
        b = '{8'h11, 8'h12, 8'h13, 8'h14};
        model_pack(b, 1'b0);
        foreach (b[i]) push(b[i]);
        for (int k = 0; k < 20; k++) tick();
        total++; if (obs_q.size() - base !== 1) $display("FAIL rmid_count got %0d want 1", obs_q.size() - base); else passed++;
        total++;
        if (obs_q.size() <= base || obs_q[base] !== exp_q[0]) $display("FAIL rmid_word got %h want %h", (base < obs_q.size()) ? obs_q[base] : 36'd0, exp_q[0]);
        else passed++;
        #3;
        total++; if (Idle !== 1'b1) $display("FAIL rmid_idle got %b want 1", Idle); else passed++;
    endtask

    task automatic test_random();
        logic [7:0] b[$];
        int base, n, budget;
        for (int it = 0; it < 6; it++) begin
            b.delete();
            base = obs_q.size();
            n = $urandom_range(1, 11);
            for (int i = 0; i < n; i++) b.push_back(8'($urandom));
            model_pack(b, 1'b1);
            tick();
            foreach (b[i]) push(b[i]);
            budget = 0;
            while (rd_ptr != wr_ptr && budget < 300) begin
                tick();
                Word_ready = 1'($urandom_range(0, 1));
                budget++;
            end
            total++; if (rd_ptr != wr_ptr) $display("FAIL rand%0d_drain got %0d want %0d", it, rd_ptr, wr_ptr); else passed++;
            for (int k = 0; k < 3; k++) begin
                tick();
                Word_ready = 1'($urandom_range(0, 1));
            end
            Flush = 1'b1;
            tick();
            Flush = 1'b0;
            Word_ready = 1'b1;
            for (int k = 0; k < 20; k++) tick();
            total++; if (obs_q.size() - base !== exp_q.size()) $display("FAIL rand%0d_count got %0d want %0d", it, obs_q.size() - base, exp_q.size()); else passed++;
            for (int i = 0; i < exp_q.size(); i++) begin
                total++;
                if (base + i >= obs_q.size() || obs_q[base+i] !== exp_q[i]) $display("FAIL rand%0d_word%0d got %h want %h", it, i, (base + i < obs_q.size()) ? obs_q[base+i] : 36'd0, exp_q[i]);
                else passed++;
            end
        end
        total++; if (stab_err !== 0) $display("FAIL stream_stability got %0d want 0", stab_err); else passed++;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush_partial();
        test_empty_flush();
        test_empty_gating();
        test_reset_midword();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fifo_byte_packer.md
# fifo_byte_packer

Read-side consumer for the BRAM-based byte FIFO. It pops 8-bit entries using the FIFO's Read/FIFO_Empty handshake and packs BYTES_PER_WORD consecutive bytes into one little-endian word. Each word is presented on a valid/ready stream with a byte-keep mask. A flush request emits any partial word, so the producer side can close out a packet.

## Interface
- DATA_WIDTH, 8: FIFO entry width; must match the FIFO's Read_data width.
- BYTES_PER_WORD, 4: bytes per output word (2..8).
- Clk  in  1  single clock, rising edge.
- Reset  in  1  synchronous, active-high; one clock and reset only.
- FIFO_Empty  in  1  FIFO empty flag.
- FIFO_Read  out  1  pop strobe to the FIFO Read input.
- FIFO_Read_data  in  DATA_WIDTH  FIFO Read_data; valid in the cycle after FIFO_Read is high.
- Flush  in  1  one-cycle request to emit the partial word.
- Word_valid  out  1  output word valid.
- Word_ready  in  1  downstream accept.
- Word_data  out  DATA_WIDTH*BYTES_PER_WORD  packed word; first popped byte in bits [7:0].
- Word_keep  out  BYTES_PER_WORD  bit i set means byte lane i is valid.
- Idle  out  1  high when there is no accumulated byte, no pop in flight, no pending flush and Word_valid is low.

## Operation
- Internal state:
  - accumulator with count, 0..BYTES_PER_WORD;
  - inflight flag (one pop outstanding at most);
  - flush_pending flag;
  - output holding register (Word_data, Word_keep, Word_valid).
- Pop rule:
  - FIFO_Read = !FIFO_Empty && !flush_pending && (count + inflight < BYTES_PER_WORD).
  - FIFO_Read is never asserted while FIFO_Empty is high.
- Capture:
  - When inflight is set, FIFO_Read_data is written into lane[count] at the clock edge.
  - count increments and inflight clears at the same edge (inflight stays set if a new pop also occurs that cycle).
- Transfer from accumulator to the output register happens when the output register is free (Word_valid low, or Word_valid && Word_ready this cycle) and either:
  - count == BYTES_PER_WORD: keep is all ones; or
  - flush_pending && !inflight && count > 0: keep has its low count bits set, and unused lanes of Word_data are zero.
- A transfer clears count to 0. A flush-driven transfer also clears flush_pending.
- Flush:
  - sets flush_pending; a Flush while flush_pending is already set has no further effect.
  - If count == 0 and no pop is in flight, flush_pending clears next cycle with no output word.
- FSM over flush_pending:
  - FILL → DRAIN on Flush.
  - DRAIN → FILL on a partial transfer, or on the empty-flush clear.
- Stream rules:
  - Word_valid holds until Word_ready.
  - Word_data and Word_keep are stable while Word_valid && !Word_ready.
  - A new word may load in the same cycle as an acceptance.
- Reset mid-operation discards the accumulator, any in-flight byte and the output word. The FIFO is reset alongside in the system.

## Timing
- Reset values: FIFO_Read=0, Word_valid=0, Word_data=0, Word_keep=0, Idle=1.
- FIFO_Read is combinational from registered state and FIFO_Empty. All other outputs are registered.
- Latency: first FIFO_Read in cycle 0 gives Word_valid high in cycle BYTES_PER_WORD+2 (cycle 6 for the default).
- Sustained throughput with Word_ready=1 and a non-empty FIFO: one word every BYTES_PER_WORD+2 cycles.
- Backpressure: the accumulator fills while the output register is held, then pops stop at count == BYTES_PER_WORD.
- Flush to partial Word_valid: 2 cycles when no pop is in flight and the output register is free.

## Structure
- Shared package fifo_pkg holds:
  - FIFO_DATA_WIDTH (8), the default for DATA_WIDTH;
  - the FILL/DRAIN state encoding;
  - a keep-mask-from-count function.
- One sub-module, word_out_reg: output holding register with valid/ready; it generates the free signal.

## Test plan
- Reset: hold Reset for 2 cycles with FIFO_Empty=0. Required: FIFO_Read=0, Word_valid=0, Word_data=0, Idle=1 during and after reset.
- Stream: write bytes 01..08 into the FIFO with Word_ready=1. Required:
  - 0x04030201 with keep 4'hF, then 0x08070605 with keep 4'hF;
  - first Word_valid 6 cycles after the first FIFO_Read.
- Backpressure: 12 bytes 01..0C with Word_ready=0 until cycle 20. Required:
  - 0x04030201 held stable;
  - FIFO_Read stops after the 8th pop;
  - after release, words arrive in order, ending with 0x0C0B0A09.
- Flush partial: bytes 0A 0B 0C, then Flush. Required: Word_data 0x000C0B0A, keep 4'h7, then Idle=1.
- Empty flush and FIFO_Empty gating:
  - Flush with nothing accumulated: no Word_valid.
  - FIFO_Empty high for 5 cycles mid-word: FIFO_Read stays 0 and the word completes correctly afterwards.
- Reset mid-word: reset after 2 bytes, then feed 4 new bytes 11..14. Required: a single word 0x14131211.
